// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: fetch/decode/execute sequencer driving the
// datapath selects and strobes from a registered copy of the fetched word.
//
// Memory handshake: mem_req is held high (with addrmode/memwrite stable) in
// FETCH, MEMRD and MEMWR until mem_ready is seen; a transfer completes on the
// cycle where mem_req and mem_ready are both high, and the FSM leaves the
// state on the following edge.
module multicycle_control #(
  parameter int ALUCTRL_W    = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 eq,
  input  logic                 lt,
  input  logic                 ltu,
  output logic [3:0]           state,
  output logic                 irwrite,
  output logic                 pcwrite,
  output logic [1:0]           pcsrc,
  output logic                 mem_req,
  output logic                 memwrite,
  output logic [2:0]           addrmode,
  output logic [1:0]           alusrca,
  output logic [1:0]           alusrcb,
  output logic [ALUCTRL_W-1:0] aluctrl,
  output logic [2:0]           immsrc,
  output logic                 regwrite,
  output logic [1:0]           resultsrc,
  output logic                 illegal
);

  localparam int WCNT_W = $clog2(MEM_WAIT_MAX + 2);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    EXEC_I  = 4'd3,
    MEMADDR = 4'd4,
    MEMRD   = 4'd5,
    MEMWR   = 4'd6,
    WB      = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    UPPER   = 4'd10,
    TRAP    = 4'd15
  } state_t;

  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_I     = 7'd19;
  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_AUIPC = 7'd23;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(10);

  state_t            state_q, state_d;
  logic [31:0]       ir;
  logic [WCNT_W-1:0] wait_cnt;
  logic              illegal_q;
  logic              post_rst;
  logic              waiting;
  logic              wait_expired;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign f7b5   = ir[30];

  assign state   = state_q;
  assign illegal = illegal_q;

  // A memory state with mem_ready low is a wait cycle; the last tolerated one
  // is when the counter already holds MEM_WAIT_MAX.
  assign waiting      = ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR)) && !mem_ready;
  assign wait_expired = waiting && (wait_cnt == WCNT_W'(MEM_WAIT_MAX));

  // funct3 to ALU op; alt selects sub (funct3=0) or sra (funct3=5)
  function automatic logic [ALUCTRL_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_op = ALU_SLL;
      3'd2:    alu_op = ALU_SLT;
      3'd3:    alu_op = ALU_SLTU;
      3'd4:    alu_op = ALU_XOR;
      3'd5:    alu_op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Instruction register, wait counter, sticky trap flag and post-reset marker
  always_ff @(posedge clk) begin
    if (rst) begin
      ir        <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      post_rst  <= 1'b1;
    end else begin
      post_rst <= 1'b0;
      if (irwrite) ir <= instr;
      if (state_d != state_q) wait_cnt <= '0;
      else if (waiting)       wait_cnt <= wait_cnt + WCNT_W'(1);
      illegal_q <= illegal_q | (state_d == TRAP);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (wait_expired)               state_d = TRAP;
        else if (mem_ready && !post_rst) state_d = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_R:               state_d = EXEC_R;
          OP_I:               state_d = EXEC_I;
          OP_LOAD, OP_STORE:  state_d = MEMADDR;
          OP_BR:              state_d = BRANCH;
          OP_JAL, OP_JALR:    state_d = JUMP;
          OP_LUI, OP_AUIPC:   state_d = UPPER;
          default:            state_d = TRAP;
        endcase
      end
      EXEC_R, EXEC_I: state_d = WB;
      MEMADDR: begin
        if (opcode == OP_LOAD)
          state_d = ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7)) ? TRAP : MEMRD;
        else
          state_d = (funct3 >= 3'd3) ? TRAP : MEMWR;
      end
      MEMRD: begin
        if (wait_expired)   state_d = TRAP;
        else if (mem_ready) state_d = WB;
      end
      MEMWR: begin
        if (wait_expired)   state_d = TRAP;
        else if (mem_ready) state_d = FETCH;
      end
      BRANCH:            state_d = ((funct3 == 3'd2) || (funct3 == 3'd3)) ? TRAP : FETCH;
      WB, JUMP, UPPER:   state_d = FETCH;
      TRAP:              state_d = TRAP;
      default:           state_d = TRAP;
    endcase
  end

  // Output decode per state; strobes forced low while rst is high
  always_comb begin
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    pcsrc     = 2'd0;
    mem_req   = 1'b0;
    memwrite  = 1'b0;
    addrmode  = 3'd0;
    alusrca   = 2'd0;
    alusrcb   = 2'd0;
    aluctrl   = ALU_ADD;
    immsrc    = 3'd7;
    regwrite  = 1'b0;
    resultsrc = 2'd0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready && !post_rst) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
        end
      end
      EXEC_R: aluctrl = alu_op(funct3, f7b5);
      EXEC_I: begin
        alusrcb = 2'd1;
        immsrc  = 3'd0;
        aluctrl = alu_op(funct3, f7b5 && (funct3 == 3'd5));
      end
      WB: begin
        regwrite  = 1'b1;
        resultsrc = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
      end
      MEMADDR: begin
        alusrcb = 2'd1;
        immsrc  = (opcode == OP_STORE) ? 3'd2 : 3'd0;
      end
      MEMRD: begin
        mem_req  = 1'b1;
        addrmode = funct3;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        addrmode = funct3;
      end
      BRANCH: begin
        aluctrl = ALU_SUB;
        immsrc  = 3'd3;
        pcsrc   = 2'd1;
        case (funct3)
          3'd0:    pcwrite = eq;
          3'd1:    pcwrite = !eq;
          3'd4:    pcwrite = lt;
          3'd5:    pcwrite = !lt;
          3'd6:    pcwrite = ltu;
          3'd7:    pcwrite = !ltu;
          default: pcwrite = 1'b0;
        endcase
      end
      JUMP: begin
        regwrite  = 1'b1;
        resultsrc = 2'd2;
        pcwrite   = 1'b1;
        if (opcode == OP_JALR) begin
          pcsrc   = 2'd2;
          alusrcb = 2'd1;
          immsrc  = 3'd0;
        end else begin
          pcsrc  = 2'd1;
          immsrc = 3'd5;
        end
      end
      UPPER: begin
        regwrite = 1'b1;
        immsrc   = 3'd4;
        alusrcb  = 2'd1;
        alusrca  = (opcode == OP_LUI) ? 2'd2 : 2'd1;
      end
      default: ;
    endcase
    if (rst) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      mem_req  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction walks, memory waits,
// branch outcomes, trap entry and reset recovery.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        eq, lt, ltu;
  logic [3:0]  state;
  logic        irwrite, pcwrite, mem_req, memwrite, regwrite, illegal;
  logic [1:0]  pcsrc, alusrca, alusrcb, resultsrc;
  logic [2:0]  addrmode, immsrc;
  logic [3:0]  aluctrl;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h40208133;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_ADDI = 32'hC0000093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_LD   = 32'h0000B183;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_JALR = 32'h000100E7;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  multicycle_control #(.ALUCTRL_W(4), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .eq(eq), .lt(lt), .ltu(ltu), .state(state), .irwrite(irwrite),
    .pcwrite(pcwrite), .pcsrc(pcsrc), .mem_req(mem_req), .memwrite(memwrite),
    .addrmode(addrmode), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluctrl(aluctrl), .immsrc(immsrc), .regwrite(regwrite),
    .resultsrc(resultsrc), .illegal(illegal)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present a word in FETCH with mem_ready high; returns in the dispatched state
  task automatic fetch(input logic [31:0] word);
    instr = word;
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", 32'(state), 0);
    chk("fetch_irwrite", 32'(irwrite), 1);
    step();
    chk("decode_state", 32'(state), 1);
    step();
  endtask

  // watchdog
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [3:0] e;
    rst = 1'b1; instr = '0; mem_ready = 1'b0; eq = 1'b0; lt = 1'b0; ltu = 1'b0;
    step(); step();
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_memreq", 32'(mem_req), 0);
    chk("rst_illegal", 32'(illegal), 0);

    // first cycle after release: only mem_req, even with mem_ready high
    rst = 1'b0; instr = I_ADD; mem_ready = 1'b1;
    #1;
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_memreq", 32'(mem_req), 1);
    chk("post_rst_irwrite", 32'(irwrite), 0);
    chk("post_rst_pcwrite", 32'(pcwrite), 0);
    step();

    // add: FETCH, DECODE, EXEC_R, WB, back to FETCH
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_q.push_back(4'd7); exp_q.push_back(4'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      e = exp_q.pop_front();
      chk("add_state", 32'(state), 32'(e));
      chk("add_regwrite", 32'(regwrite), (e == 4'd7) ? 1 : 0);
      if (e == 4'd2) chk("add_aluctrl", 32'(aluctrl), 0);
      if (e == 4'd7) chk("add_resultsrc", 32'(resultsrc), 0);
      if (i == 0) begin
        chk("add_pcwrite", 32'(pcwrite), 1);
        chk("add_pcsrc", 32'(pcsrc), 0);
      end
      if (i < 4) step();
    end

    // sub
    fetch(I_SUB);
    #1; chk("sub_state", 32'(state), 2); chk("sub_aluctrl", 32'(aluctrl), 1);
    step(); #1; chk("sub_wb", 32'(state), 7);
    step(); #1; chk("sub_fetch", 32'(state), 0);

    // srai: funct7[5] selects sra for shifts
    fetch(I_SRAI);
    #1; chk("srai_state", 32'(state), 3); chk("srai_aluctrl", 32'(aluctrl), 10);
    chk("srai_alusrcb", 32'(alusrcb), 1); chk("srai_immsrc", 32'(immsrc), 0);
    step(); step(); #1; chk("srai_fetch", 32'(state), 0);

    // addi with imm bit 30 set is still add
    fetch(I_ADDI);
    #1; chk("addi_state", 32'(state), 3); chk("addi_aluctrl", 32'(aluctrl), 0);
    step(); step(); #1; chk("addi_fetch", 32'(state), 0);

    // lw with 3 wait cycles in MEMRD
    fetch(I_LW);
    #1; chk("lw_memaddr", 32'(state), 4); chk("lw_alusrcb", 32'(alusrcb), 1);
    chk("lw_immsrc", 32'(immsrc), 0); chk("lw_aluctrl", 32'(aluctrl), 0);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      chk("lw_memrd", 32'(state), 5);
      chk("lw_memreq", 32'(mem_req), 1);
      chk("lw_addrmode", 32'(addrmode), 2);
      step();
    end
    #1; chk("lw_wb", 32'(state), 7); chk("lw_regwrite", 32'(regwrite), 1);
    chk("lw_resultsrc", 32'(resultsrc), 1);
    step(); #1; chk("lw_fetch", 32'(state), 0); chk("lw_regwrite_off", 32'(regwrite), 0);

    // blt taken then not taken
    fetch(I_BLT); lt = 1'b1;
    #1; chk("blt1_state", 32'(state), 8); chk("blt1_pcwrite", 32'(pcwrite), 1);
    chk("blt1_pcsrc", 32'(pcsrc), 1); chk("blt1_aluctrl", 32'(aluctrl), 1);
    chk("blt1_immsrc", 32'(immsrc), 3);
    step(); #1; chk("blt1_fetch", 32'(state), 0);
    fetch(I_BLT); lt = 1'b0;
    #1; chk("blt0_state", 32'(state), 8); chk("blt0_pcwrite", 32'(pcwrite), 0);
    step(); #1; chk("blt0_fetch", 32'(state), 0);

    // lui
    fetch(I_LUI);
    #1; chk("lui_state", 32'(state), 10); chk("lui_alusrca", 32'(alusrca), 2);
    chk("lui_immsrc", 32'(immsrc), 4); chk("lui_regwrite", 32'(regwrite), 1);
    step(); #1; chk("lui_fetch", 32'(state), 0);

    // jalr
    fetch(I_JALR);
    #1; chk("jalr_state", 32'(state), 9); chk("jalr_pcsrc", 32'(pcsrc), 2);
    chk("jalr_pcwrite", 32'(pcwrite), 1); chk("jalr_resultsrc", 32'(resultsrc), 2);
    chk("jalr_alusrcb", 32'(alusrcb), 1); chk("jalr_immsrc", 32'(immsrc), 0);
    step(); #1; chk("jalr_fetch", 32'(state), 0);

    // sw, then reset in the middle of MEMWR
    fetch(I_SW);
    #1; chk("sw_memaddr", 32'(state), 4); chk("sw_immsrc", 32'(immsrc), 2);
    mem_ready = 1'b0;
    step(); #1;
    chk("sw_memwr", 32'(state), 6); chk("sw_memwrite", 32'(memwrite), 1);
    chk("sw_addrmode", 32'(addrmode), 2);
    step();
    rst = 1'b1;
    #1; chk("sw_rst_memwrite", 32'(memwrite), 0); chk("sw_rst_memreq", 32'(mem_req), 0);
    step();
    rst = 1'b0; mem_ready = 1'b0;
    #1; chk("sw_after_rst_state", 32'(state), 0); chk("sw_after_rst_memwrite", 32'(memwrite), 0);

    // FETCH stall: 16th consecutive wait cycle traps (this is stall 1)
    step();
    for (int i = 2; i <= 16; i++) begin
      #1; chk("stall_fetch", 32'(state), 0);
      step();
    end
    #1; chk("stall_trap", 32'(state), 15); chk("stall_illegal", 32'(illegal), 1);
    mem_ready = 1'b1;
    step(); #1;
    chk("trap_hold", 32'(state), 15); chk("trap_memreq", 32'(mem_req), 0);
    chk("trap_irwrite", 32'(irwrite), 0);

    // illegal opcode traps, persists, and one rst cycle recovers
    rst = 1'b1; step(); rst = 1'b0;
    #1; chk("rec1_state", 32'(state), 0); chk("rec1_illegal", 32'(illegal), 0);
    step();
    fetch(I_BAD);
    #1; chk("bad_trap", 32'(state), 15); chk("bad_illegal", 32'(illegal), 1);
    step(); step();
    #1; chk("bad_hold", 32'(state), 15); chk("bad_pcwrite", 32'(pcwrite), 0);
    chk("bad_illegal_hold", 32'(illegal), 1);
    rst = 1'b1; step(); rst = 1'b0;
    #1; chk("rec2_state", 32'(state), 0); chk("rec2_illegal", 32'(illegal), 0);
    step();

    // load with unsupported funct3 traps from MEMADDR
    fetch(I_LD);
    #1; chk("ld_memaddr", 32'(state), 4);
    step(); #1; chk("ld_trap", 32'(state), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
